// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: segment width, blank pattern and the
// scan-index to active-low anode decoder.
package seg_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned MAX_DIGITS = 32;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Digit 0 is the leftmost digit and owns the MSB of the anode vector.
  function automatic logic [MAX_DIGITS-1:0] idx_to_anode(input int unsigned idx,
                                                         input int unsigned n);
    idx_to_anode = ~(MAX_DIGITS'(1) << (n - 1 - idx));
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running 0..SCAN_DIV-1 counter; tick_c marks the last cycle of each slot.
// Also used by the clock divider.
module scan_prescaler #(
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic fast_clk,
  input  logic rst,
  output logic tick_c
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt;

  assign tick_c = (cnt == CNT_LAST);

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed N-digit common-anode driver with once-per-frame data capture.
// Optional per-digit blinking is built when SEVEN_SEG_SCANNER_BLINK_EN is defined.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SCAN_DIV     = 1,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                        fast_clk,
  input  logic                        rst,
  input  logic [SEG_W*NUM_DIGITS-1:0] spin_digits,
  input  logic [SEG_W*NUM_DIGITS-1:0] score_digits,
  input  logic                        is_spinning,
  input  logic                        sel,
  input  logic [NUM_DIGITS-1:0]       blink_mask,
  output logic [SEG_W-1:0]            seg,
  output logic [NUM_DIGITS-1:0]       an,
  output logic                        frame_start
);

  localparam int unsigned POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_DIGITS - 1);

  logic                                tick_c;
  logic [POS_W-1:0]                    pos;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]    frame_buf;
  logic                                last_pos_c;
  logic                                load_c;
  logic                                show_score_c;
  logic                                blank_c;
  logic [NUM_DIGITS-1:0]               anode_c;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_prescaler (
    .fast_clk (fast_clk),
    .rst      (rst),
    .tick_c   (tick_c)
  );

  assign last_pos_c   = (pos == POS_LAST);
  assign load_c       = tick_c && last_pos_c;
  assign show_score_c = !is_spinning && sel;
  assign anode_c      = NUM_DIGITS'(idx_to_anode(32'(pos), NUM_DIGITS));

`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  localparam int unsigned BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic [BF_W-1:0]       frame_cnt;
  logic                  blink_phase;
  logic [NUM_DIGITS-1:0] mask_q;

  // Blink phase advances once per BLINK_FRAMES frame loads.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      mask_q      <= '0;
    end else if (load_c) begin
      mask_q <= blink_mask;
      if (frame_cnt == BF_LAST) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + BF_W'(1);
      end
    end
  end

  assign blank_c = blink_phase && mask_q[pos];
`else
  logic unused_blink;
  assign unused_blink = &{1'b0, blink_mask, 32'(BLINK_FRAMES)};
  assign blank_c      = 1'b0;
`endif

  // Scan datapath: drive the current digit, then capture the next frame
  // after the last digit so a frame never mixes old and new data.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      seg         <= SEG_BLANK;
      an          <= '1;
      frame_start <= 1'b0;
      pos         <= '0;
      frame_buf   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      frame_start <= tick_c && (pos == '0);
      if (tick_c) begin
        an  <= anode_c;
        seg <= blank_c ? SEG_BLANK : frame_buf[pos];
        pos <= last_pos_c ? '0 : pos + POS_W'(1);
        if (last_pos_c) begin
          frame_buf <= show_score_c ? score_digits : spin_digits;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench: 4-digit/SCAN_DIV=1 scanner driven from a vector table, plus
// hand sequences for mid-frame reset and an 8-digit/SCAN_DIV=3 instance.
module tb_seven_seg_scanner;

`ifdef SEVEN_SEG_SCANNER_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic        fast_clk = 1'b0;
  logic        rst;
  logic        rst_b;

  logic [27:0] spin_a;
  logic [27:0] score_a;
  logic        is_spinning_a;
  logic        sel_a;
  logic [3:0]  blink_mask_a;
  logic [6:0]  seg_a;
  logic [3:0]  an_a;
  logic        fs_a;

  logic [55:0] spin_b;
  logic [55:0] score_b;
  logic [6:0]  seg_b;
  logic [7:0]  an_b;
  logic        fs_b;

  int checks = 0;
  int passed = 0;

  always #5 fast_clk = ~fast_clk;

  seven_seg_scanner #(
    .NUM_DIGITS   (4),
    .SCAN_DIV     (1),
    .BLINK_FRAMES (2)
  ) dut_a (
    .fast_clk     (fast_clk),
    .rst          (rst),
    .spin_digits  (spin_a),
    .score_digits (score_a),
    .is_spinning  (is_spinning_a),
    .sel          (sel_a),
    .blink_mask   (blink_mask_a),
    .seg          (seg_a),
    .an           (an_a),
    .frame_start  (fs_a)
  );

  seven_seg_scanner #(
    .NUM_DIGITS (8),
    .SCAN_DIV   (3)
  ) dut_b (
    .fast_clk     (fast_clk),
    .rst          (rst_b),
    .spin_digits  (spin_b),
    .score_digits (score_b),
    .is_spinning  (1'b1),
    .sel          (1'b0),
    .blink_mask   (8'h00),
    .seg          (seg_b),
    .an           (an_b),
    .frame_start  (fs_b)
  );

  typedef struct {
    logic       is_sp;
    logic       sel;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fs;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check_a(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                         input logic e_fs);
    check({name, ".an"},  32'(an_a),  32'(e_an));
    check({name, ".seg"}, 32'(seg_a), 32'(e_seg));
    check({name, ".fs"},  32'(fs_a),  32'(e_fs));
  endtask

  initial begin
    logic [6:0] d1_score;
    logic [6:0] d1_spin;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_fs;
    int         p;

    d1_score = BLINK ? 7'h7F : 7'h79;
    d1_spin  = BLINK ? 7'h7F : 7'h22;

    // Each row: inputs present at the edge, outputs expected after it.
    vecs[0]  = '{1'b1, 1'b1, 4'b0111, 7'h7F, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 4'b1011, 7'h7F, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 4'b1101, 7'h7F, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 4'b1110, 7'h7F, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 4'b0111, 7'h11, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 4'b1011, 7'h22, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'b1101, 7'h33, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 4'b1110, 7'h44, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 4'b0111, 7'h40, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 4'b1011, d1_score, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 4'b1101, 7'h24, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 4'b1110, 7'h30, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'b0111, 7'h11, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 4'b1011, d1_spin, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 4'b1101, 7'h33, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 4'b1110, 7'h44, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 4'b0111, 7'h11, 1'b1};
    vecs[17] = '{1'b0, 1'b0, 4'b1011, 7'h22, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 4'b1101, 7'h33, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 4'b1110, 7'h44, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 4'b0111, 7'h40, 1'b1};
    vecs[21] = '{1'b0, 1'b1, 4'b1011, 7'h79, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 4'b1101, 7'h24, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 4'b1110, 7'h30, 1'b0};

    rst           = 1'b1;
    rst_b         = 1'b1;
    spin_a        = {7'h44, 7'h33, 7'h22, 7'h11};
    score_a       = {7'h30, 7'h24, 7'h79, 7'h40};
    is_spinning_a = 1'b1;
    sel_a         = 1'b1;
    blink_mask_a  = 4'b0010;
    score_b       = '0;
    for (int d = 0; d < 8; d++) spin_b[7*d +: 7] = 7'(8'h10 + d);

    repeat (3) @(negedge fast_clk);
    check_a("reset", 4'hF, 7'h7F, 1'b0);

    // Table run on the 4-digit instance, one tick per cycle.
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      is_spinning_a = vecs[i].is_sp;
      sel_a         = vecs[i].sel;
      @(posedge fast_clk);
      @(negedge fast_clk);
      check_a($sformatf("vec%0d", i + 1), vecs[i].an, vecs[i].seg, vecs[i].fs);
    end

    // Reset in the middle of a pos-2 slot blanks immediately.
    repeat (3) begin
      @(posedge fast_clk);
      @(negedge fast_clk);
    end
    check("pre_rst.an", 32'(an_a), 32'(4'b1101));
    rst = 1'b1;
    #1;
    check_a("midrst", 4'hF, 7'h7F, 1'b0);
    @(posedge fast_clk);
    @(negedge fast_clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge fast_clk);
      @(negedge fast_clk);
      case (i)
        0: check_a("post_rst1", 4'b0111, 7'h7F, 1'b1);
        1: check_a("post_rst2", 4'b1011, 7'h7F, 1'b0);
        2: check_a("post_rst3", 4'b1101, 7'h7F, 1'b0);
        3: check_a("post_rst4", 4'b1110, 7'h7F, 1'b0);
        default: check_a("post_rst5", 4'b0111, 7'h40, 1'b1);
      endcase
    end

    // 8 digits, 3-cycle slots: ticks on cycles 3,6,9,..; frame = 24 cycles.
    rst_b = 1'b0;
    for (int c = 1; c <= 51; c++) begin
      @(posedge fast_clk);
      @(negedge fast_clk);
      p = ((c / 3) - 1) % 8;
      if (c < 3) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
      end else begin
        exp_an  = ~(8'h80 >> p);
        exp_seg = (c < 27) ? 7'h7F : 7'(8'h10 + p);
      end
      exp_fs = ((c % 24) == 3);
      check($sformatf("b.an c%0d", c),  32'(an_b),  32'(exp_an));
      check($sformatf("b.seg c%0d", c), 32'(seg_b), 32'(exp_seg));
      check($sformatf("b.fs c%0d", c),  32'(fs_b),  32'(exp_fs));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
